// File: rtl/ps2_dir_if.sv
// Bundle between the PS/2 receiver/consumer side and the direction scheduler.
interface ps2_dir_if;
    logic [9:0] ps2_code;
    logic       ps2_ready;
    logic       flush;
    logic       cmd_valid;
    logic [3:0] cmd_dir;
    logic       cmd_ack;
    logic [3:0] held;
    logic       overflow;

    modport master (
        output ps2_code, ps2_ready, flush, cmd_ack,
        input  cmd_valid, cmd_dir, held, overflow
    );

    modport slave (
        input  ps2_code, ps2_ready, flush, cmd_ack,
        output cmd_valid, cmd_dir, held, overflow
    );
endinterface

// File: rtl/ps2_dir_scheduler.sv
// Arrow-key press tracker feeding a deduplicating command FIFO.
// Define PS2_AUTOREPEAT_EN to re-issue the held arrow every REPEAT_CYCLES.
module ps2_dir_scheduler #(
    parameter int DEPTH         = 4,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input logic      clk,
    input logic      rst,
    ps2_dir_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        REPEAT_CYCLES < 2) begin : g_bad_cfg
        $error("ps2_dir_scheduler: unsupported parameters");
    end

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt, tail_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [3:0]    held_q, held_nxt, head_q, head_nxt;
    logic          ovf_q, ovf_nxt;

    logic [3:0] key_dir, push_dir, rpt_dir;
    logic       ev, make, brk, key_push, rpt_push;
    logic       push_req, empty, full, dup, pop, accept, push_ok;

    always_comb begin
        key_dir = 4'b0000;
        unique case (bus.ps2_code[7:0])
            8'h75:   key_dir = 4'b0001;
            8'h72:   key_dir = 4'b0010;
            8'h6B:   key_dir = 4'b0100;
            8'h74:   key_dir = 4'b1000;
            default: key_dir = 4'b0000;
        endcase
    end

    assign ev   = bus.ps2_ready & bus.ps2_code[9] & (key_dir != 4'b0000);
    assign make = ev & ~bus.ps2_code[8];
    assign brk  = ev & bus.ps2_code[8];

    // Keyboard typematic makes of an already-held arrow are swallowed here.
    assign key_push = make & ((held_q & key_dir) == 4'b0000);

    always_comb begin
        held_nxt = held_q;
        if (brk)
            held_nxt = held_q & ~key_dir;
        else if (make)
            held_nxt = held_q | key_dir;
    end

`ifdef PS2_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] TERM = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_cnt;

    assign rpt_push = (held_q != 4'b0000) && (rpt_cnt == TERM) && empty;

    always_comb begin
        rpt_dir = 4'b0000;
        priority case (1'b1)
            held_q[0]: rpt_dir = 4'b0001;
            held_q[1]: rpt_dir = 4'b0010;
            held_q[2]: rpt_dir = 4'b0100;
            held_q[3]: rpt_dir = 4'b1000;
            default:   rpt_dir = 4'b0000;
        endcase
    end

    // Saturates at TERM while the queue is busy so the repeat fires on drain.
    always_ff @(posedge clk) begin
        if (rst)
            rpt_cnt <= '0;
        else if (held_nxt == 4'b0000 || push_ok)
            rpt_cnt <= '0;
        else if (rpt_cnt != TERM)
            rpt_cnt <= rpt_cnt + RW'(1);
    end
`else
    assign rpt_push = 1'b0;
    assign rpt_dir  = 4'b0000;
`endif

    assign push_req = key_push | rpt_push;
    assign push_dir = key_push ? key_dir : rpt_dir;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign tail_ptr = wr_ptr - PW'(1);
    assign dup      = ~empty & (mem[tail_ptr] == push_dir);
    assign pop      = ~empty & bus.cmd_ack;
    assign accept   = push_req & ~dup & ~bus.flush;
    assign push_ok  = accept & (~full | pop);
    assign ovf_nxt  = accept & full & ~pop;

    always_comb begin
        count_nxt = count + CW'(push_ok) - CW'(pop);
        rd_nxt    = rd_ptr + PW'(pop);
        wr_nxt    = wr_ptr + PW'(push_ok);
        if (bus.flush) begin
            count_nxt = '0;
            rd_nxt    = '0;
            wr_nxt    = '0;
        end
        // A push into a queue that drains to one entry becomes the new head.
        if (count_nxt == '0)
            head_nxt = 4'b0000;
        else if (push_ok && rd_nxt == wr_ptr)
            head_nxt = push_dir;
        else
            head_nxt = mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            held_q <= 4'b0000;
            head_q <= 4'b0000;
            ovf_q  <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
            count  <= count_nxt;
            held_q <= held_nxt;
            head_q <= head_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    assign bus.cmd_valid = ~empty;
    assign bus.cmd_dir   = head_q;
    assign bus.held      = held_q;
    assign bus.overflow  = ovf_q;
endmodule
